image_vector_fetch: RTL and testbench

IMAGE_VECTOR_FETCH -- requirements
Module: image_vector_fetch

---
 rtl/image_vector_fetch.sv | 78 +++++++
 tb/tb_image_vector_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/image_vector_fetch.sv
// image_vector_fetch: scans a frame as LANES-pixel vectors with a valid/ready output handshake.
// Optional backpressure counter enabled with macro IMAGE_FETCH_STALL_CNT_EN.
module image_vector_fetch #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int PIX_SIZE     = 8,
  parameter int LANES        = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [15:0]        base_addr,
  output logic [15:0]        Addr,
  input  logic [15:0][15:0]  RD,
  output logic [15:0][15:0]  vec_out,
  output logic               vec_valid,
  input  logic               vec_ready,
  output logic [10:0]        vec_index,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt
);
  localparam logic [10:0] LAST = 11'(IMAGE_WIDTH * IMAGE_HEIGHT / LANES - 1);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
  state_t state;
  logic unused_rd;
  assign unused_rd = ^RD;
  // scan sequencer: fetch a vector, hold it until accepted, advance or finish
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state     <= IDLE;
      Addr      <= '0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      vec_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          Addr      <= base_addr;
          vec_index <= '0;
          busy      <= 1'b1;
          state     <= FETCH;
        end
        FETCH: begin
          for (int i = 0; i < 16; i++)
            vec_out[i] <= (i < LANES) ? {{(16-PIX_SIZE){1'b0}}, RD[i][PIX_SIZE-1:0]} : 16'h0;
          vec_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (vec_ready) begin
          vec_valid <= 1'b0;
          if (vec_index == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            Addr      <= Addr + 16'(LANES);
            vec_index <= vec_index + 11'd1;
            state     <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
`ifdef IMAGE_FETCH_STALL_CNT_EN
  // saturating count of cycles a valid vector waits on the consumer
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (vec_valid && !vec_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_image_vector_fetch.sv
// tb_image_vector_fetch: directed checks of frame scan, backpressure, wrap, reset and restart handling.
module tb_image_vector_fetch;
  logic CLK = 1'b0, RST_N, start = 1'b0, vec_ready = 1'b0;
  logic vec_valid, busy, done;
  logic [15:0] base_addr = '0, Addr, stall_cnt;
  logic [15:0][15:0] RD, vec_out;
  logic [10:0] vec_index;
  logic [7:0] upper = 8'h00;
  int n_checks = 0, n_err = 0;
  bit ok;
  int nvec, nbad, ndone, lat;
  logic [15:0] addr1;

  always #5 CLK = ~CLK;

  // memory model: pixel at address a holds a[7:0], with a programmable upper byte
  always_comb
    for (int i = 0; i < 16; i++) RD[i] = {upper, 8'(Addr + 16'(i))};

  image_vector_fetch dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr), .Addr(Addr), .RD(RD),
    .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_index(vec_index),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_vec(input int idx, output bit found);
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++)
      if (vec_valid && vec_index == 11'(idx)) found = 1'b1;
      else tick();
  endtask

  task automatic frame(input logic [15:0] base, output int nv, output int nb, output int nd,
                       output int first_lat, output logic [15:0] a1);
    logic [15:0] e, e7;
    int last_c;
    nv = 0; nb = 0; nd = 0; first_lat = 0; a1 = '0; last_c = -1;
    vec_ready = 1'b1;
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000 && nd == 0; c++) begin
      if (vec_valid) begin
        e  = base + 16'(nv * 8);
        e7 = e + 16'd7;
        if (nv == 0) begin
          first_lat = c + 1;
          check("first_lane0", vec_out[0], {8'h00, e[7:0]});
          check("first_lane7", vec_out[7], {8'h00, e7[7:0]});
          check("first_lane8_zero", vec_out[8], 16'h0);
        end else if (c - last_c != 2) nb++;
        if (nv == 1) a1 = Addr;
        if (Addr != e || vec_index != 11'(nv) || !busy || vec_out[0] != {8'h00, e[7:0]} ||
            vec_out[7] != {8'h00, e7[7:0]} || vec_out[8] != 16'h0 || vec_out[15] != 16'h0) nb++;
        last_c = c;
        nv++;
      end
      if (done) begin
        nd++;
        if (busy) nb++;
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      if (done) nd++;
      if (vec_valid || busy) nb++;
      tick();
    end
  endtask

  initial begin
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("rst_addr", Addr, 0);
    check("rst_valid", vec_valid, 0);
    check("rst_index", vec_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_vec_out", 32'(|vec_out), 0);
    tick(); tick();
    // start on the very first edge after reset release
    RST_N = 1'b1;
    base_addr = 16'h0040;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_edge_busy", busy, 1);
    check("first_edge_addr", Addr, 16'h0040);
    RST_N = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    tick();
    RST_N = 1'b1;
    tick();
    // full frame from base 0
    frame(16'h0000, nvec, nbad, ndone, lat, addr1);
    check("frameA_nvec", nvec, 1152);
    check("frameA_bad", nbad, 0);
    check("frameA_done", ndone, 1);
    check("frameA_latency", lat, 2);
    check("frameA_final_addr", Addr, 16'd9208);
    check("frameA_final_index", vec_index, 11'd1151);
    // backpressure on vector 3
    base_addr = 16'h0000;
    vec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(3, ok);
    check("stall_reach_v3", ok, 1);
    vec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_index", vec_index, 3);
      check("stall_lane0", vec_out[0], 16'h0018);
      check("stall_valid", vec_valid, 1);
    end
`ifdef IMAGE_FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`else
    check("stall_cnt", stall_cnt, 0);
`endif
    vec_ready = 1'b1;
    // asynchronous reset while holding vector 100
    wait_vec(100, ok);
    check("reach_v100", ok, 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_addr", Addr, 0);
    check("mid_rst_valid", vec_valid, 0);
    check("mid_rst_index", vec_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_stall", stall_cnt, 0);
    check("mid_rst_vec_out", 32'(|vec_out), 0);
    tick(); tick();
    RST_N = 1'b1;
    nbad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (vec_valid || busy) nbad++;
    end
    check("post_rst_quiet", nbad, 0);
    // address wrap with junk upper byte on every lane
    upper = 8'hAB;
    frame(16'hFFFC, nvec, nbad, ndone, lat, addr1);
    check("wrap_second_addr", addr1, 16'h0004);
    check("wrap_nvec", nvec, 1152);
    check("wrap_bad", nbad, 0);
    check("wrap_done", ndone, 1);
    upper = 8'h00;
    // start re-asserted mid-frame is ignored
    base_addr = 16'h0100;
    vec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(10, ok);
    check("reach_v10", ok, 1);
    start = 1'b1;
    base_addr = 16'h5000;
    tick();
    start = 1'b0;
    check("restart_addr", Addr, 16'h0158);
    check("restart_index", vec_index, 11);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++)
      if (done) ok = 1'b1;
      else tick();
    check("restart_done", ok, 1);
    check("restart_final_addr", Addr, 16'h24F8);
    check("restart_final_index", vec_index, 11'd1151);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
